// File: rtl/ampm_clock_counter_if.sv
// Control and time-of-day bus of the 12-hour clock counter.
// master drives the mode/buttons and reads the time; slave is the counter.
interface ampm_clock_counter_if;
  logic       set_mode;
  logic       inc_hour;
  logic       inc_min;
  logic [3:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       morning_signal;
  logic       after_signal;
  logic       sec_tick;

  modport master (
    output set_mode, inc_hour, inc_min,
    input  hour, minute, second, morning_signal, after_signal, sec_tick
  );

  modport slave (
    input  set_mode, inc_hour, inc_min,
    output hour, minute, second, morning_signal, after_signal, sec_tick
  );
endinterface

// File: rtl/ampm_clock_counter.sv
// 12-hour HH:MM:SS counter with AM/PM flags, CLK_HZ prescaler and RUN/SET button setting.
// Every output is registered; button edges apply one cycle after they are sampled.
module ampm_clock_counter #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ampm_clock_counter_if.slave  bus
);

  localparam int             PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [3:0]    r_hour,  w_hour_nxt;
  logic [5:0]    r_min,   w_min_nxt;
  logic [5:0]    r_sec,   w_sec_nxt;
  logic          r_pm,    w_pm_nxt;
  logic          r_am;
  logic          r_tick,  w_tick_nxt;
  logic          r_prev_hour, r_prev_min;
  logic          w_hour_edge, w_min_edge, w_hour_step;

  assign w_hour_edge = bus.inc_hour & ~r_prev_hour;
  assign w_min_edge  = bus.inc_min  & ~r_prev_min;

  always_comb begin
    w_state_nxt = ST_RUN;
    if (bus.set_mode) w_state_nxt = ST_SET;
  end

  always_comb begin
    w_presc_nxt = r_presc;
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    w_hour_nxt  = r_hour;
    w_pm_nxt    = r_pm;
    w_tick_nxt  = 1'b0;
    w_hour_step = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (r_presc == PRESC_LAST) begin
          w_presc_nxt = '0;
          w_tick_nxt  = 1'b1;
          if (r_sec == 6'd59) begin
            w_sec_nxt = 6'd0;
            if (r_min == 6'd59) begin
              w_min_nxt   = 6'd0;
              w_hour_step = 1'b1;
            end else begin
              w_min_nxt = r_min + 6'd1;
            end
          end else begin
            w_sec_nxt = r_sec + 6'd1;
          end
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end
      ST_SET: begin
        // Setting never carries: minute wraps on its own, seconds stay parked at 0.
        w_presc_nxt = '0;
        w_sec_nxt   = 6'd0;
        if (w_min_edge) w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
        w_hour_step = w_hour_edge;
      end
      default: ;
    endcase
    if (w_hour_step) begin
      w_hour_nxt = (r_hour == 4'd12) ? 4'd1 : r_hour + 4'd1;
      if (r_hour == 4'd11) w_pm_nxt = ~r_pm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_presc     <= '0;
      r_hour      <= 4'd12;
      r_min       <= 6'd0;
      r_sec       <= 6'd0;
      r_pm        <= 1'b0;
      r_am        <= 1'b1;
      r_tick      <= 1'b0;
      r_prev_hour <= bus.inc_hour;
      r_prev_min  <= bus.inc_min;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_hour      <= w_hour_nxt;
      r_min       <= w_min_nxt;
      r_sec       <= w_sec_nxt;
      r_pm        <= w_pm_nxt;
      r_am        <= ~w_pm_nxt;
      r_tick      <= w_tick_nxt;
      r_prev_hour <= bus.inc_hour;
      r_prev_min  <= bus.inc_min;
    end
  end

  assign bus.hour           = r_hour;
  assign bus.minute         = r_min;
  assign bus.second         = r_sec;
  assign bus.morning_signal = r_am;
  assign bus.after_signal   = r_pm;
  assign bus.sec_tick       = r_tick;

endmodule

// File: tb/tb_ampm_clock_counter.sv
// Randomized bench for ampm_clock_counter; reference keeps time as seconds since midnight.
module tb_ampm_clock_counter;
  localparam int CLK_HZ = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ampm_clock_counter_if bus ();

  ampm_clock_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: time of day in seconds (0 = 12:00:00 AM), cycles since last second.
  int m_secs  = 0;
  int m_presc = 0;
  bit m_set   = 1'b0;
  bit m_tick  = 1'b0;
  bit m_prev_h = 1'b0;
  bit m_prev_m = 1'b0;
  int tick_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_hour();
    int h;
    h = (m_secs / 3600) % 12;
    return (h == 0) ? 12 : h;
  endfunction

  function automatic int m_min();
    return (m_secs / 60) % 60;
  endfunction

  function automatic int m_sec();
    return m_secs % 60;
  endfunction

  function automatic bit m_pm();
    return (m_secs / 3600) >= 12;
  endfunction

  task automatic model_edge();
    bit eh, em;
    int mm;
    if (!rst_n) begin
      m_secs  = 0;
      m_presc = 0;
      m_set   = 1'b0;
      m_tick  = 1'b0;
    end else begin
      eh = bus.inc_hour && !m_prev_h;
      em = bus.inc_min  && !m_prev_m;
      if (m_set) begin
        m_presc = 0;
        m_tick  = 1'b0;
        m_secs  = m_secs - (m_secs % 60);
        if (em) begin
          mm     = m_min();
          m_secs = m_secs + (((mm + 1) % 60) - mm) * 60;
        end
        if (eh) m_secs = (((m_secs / 3600) + 1) % 24) * 3600 + (m_secs % 3600);
      end else begin
        m_tick = (m_presc == CLK_HZ - 1);
        if (m_tick) begin
          m_presc = 0;
          m_secs  = (m_secs + 1) % 86400;
        end else begin
          m_presc++;
        end
      end
      m_set = bus.set_mode;
    end
    m_prev_h = bus.inc_hour;
    m_prev_m = bus.inc_min;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("hour",     bus.hour,           m_hour());
    chk("minute",   bus.minute,         m_min());
    chk("second",   bus.second,         m_sec());
    chk("am",       bus.morning_signal, !m_pm());
    chk("pm",       bus.after_signal,   m_pm());
    chk("sec_tick", bus.sec_tick,       m_tick);
    if (bus.sec_tick === 1'b1) tick_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_hour();
    bus.inc_hour = 1'b1; cycle();
    bus.inc_hour = 1'b0; cycle();
  endtask

  task automatic pulse_min();
    bus.inc_min = 1'b1; cycle();
    bus.inc_min = 1'b0; cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    bus.set_mode = 1'b0;
    bus.inc_hour = 1'b0;
    bus.inc_min  = 1'b0;

    // Reset state and first tick.
    do_reset();
    chk("rst_hour", bus.hour, 12);
    chk("rst_min",  bus.minute, 0);
    chk("rst_sec",  bus.second, 0);
    chk("rst_am",   bus.morning_signal, 1);
    chk("rst_pm",   bus.after_signal, 0);
    chk("rst_tick", bus.sec_tick, 0);
    run(3);
    chk("pre_tick", bus.sec_tick, 0);
    cycle();
    chk("t1_tick", bus.sec_tick, 1);
    chk("t1_sec",  bus.second, 1);

    // One minute of free running.
    do_reset();
    tick_cnt = 0;
    run(240);
    chk("min1_ticks", tick_cnt, 60);
    chk("min1_min",   bus.minute, 1);
    chk("min1_sec",   bus.second, 0);

    // Set 11 AM, then run across noon.
    do_reset();
    bus.set_mode = 1'b1; cycle();
    repeat (11) pulse_hour();
    chk("set11_hour", bus.hour, 11);
    chk("set11_am",   bus.morning_signal, 1);
    bus.set_mode = 1'b0; cycle();
    run(14396);
    chk("pre_noon_hour", bus.hour, 11);
    chk("pre_noon_min",  bus.minute, 59);
    chk("pre_noon_sec",  bus.second, 59);
    chk("pre_noon_am",   bus.morning_signal, 1);
    run(4);
    chk("noon_hour", bus.hour, 12);
    chk("noon_min",  bus.minute, 0);
    chk("noon_sec",  bus.second, 0);
    chk("noon_pm",   bus.after_signal, 1);
    chk("noon_am",   bus.morning_signal, 0);

    // 12 PM -> 1 PM by button keeps PM; 60 minute presses wrap without carry.
    bus.set_mode = 1'b1; cycle();
    pulse_hour();
    chk("h1_hour", bus.hour, 1);
    chk("h1_pm",   bus.after_signal, 1);
    repeat (60) pulse_min();
    chk("m60_min",  bus.minute, 0);
    chk("m60_hour", bus.hour, 1);

    // Enter SET at second 37; held button counts once; dual press applies both.
    bus.set_mode = 1'b0; cycle();
    guard = 0;
    while (m_sec() != 37 && guard < 400) begin
      cycle();
      guard++;
    end
    chk("reach_37", bus.second, 37);
    bus.set_mode = 1'b1;
    run(2);
    chk("set_sec0", bus.second, 0);
    bus.inc_min = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("hold_tick", bus.sec_tick, 0);
      chk("hold_sec",  bus.second, 0);
    end
    bus.inc_min = 1'b0; cycle();
    chk("hold_min", bus.minute, 1);
    bus.inc_hour = 1'b1; bus.inc_min = 1'b1; cycle();
    bus.inc_hour = 1'b0; bus.inc_min = 1'b0; cycle();
    chk("dual_hour", bus.hour, 2);
    chk("dual_min",  bus.minute, 2);

    // Reset mid-SET at 7:45 PM with buttons held.
    repeat (5) pulse_hour();
    repeat (43) pulse_min();
    chk("745_hour", bus.hour, 7);
    chk("745_min",  bus.minute, 45);
    chk("745_pm",   bus.after_signal, 1);
    bus.inc_hour = 1'b1; bus.inc_min = 1'b1;
    do_reset();
    chk("mid_rst_hour", bus.hour, 12);
    chk("mid_rst_min",  bus.minute, 0);
    chk("mid_rst_sec",  bus.second, 0);
    chk("mid_rst_am",   bus.morning_signal, 1);
    run(5);
    chk("held_hour", bus.hour, 12);
    chk("held_min",  bus.minute, 0);
    bus.inc_hour = 1'b0; bus.inc_min = 1'b0; bus.set_mode = 1'b0;

    // Random mode/button/reset traffic against the reference.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(299) != 0);
      if ($urandom_range(49) == 0) bus.set_mode = ~bus.set_mode;
      if ($urandom_range(3) == 0)  bus.inc_hour = $urandom_range(1);
      if ($urandom_range(3) == 0)  bus.inc_min  = $urandom_range(1);
      cycle();
      chk("inv_ampm",  bus.morning_signal ^ bus.after_signal, 1);
      chk("inv_hour",  (bus.hour >= 1) && (bus.hour <= 12), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
